// File: rtl/seq_1101_frame_tx.sv
// Serial frame transmitter: shifts a parallel word out MSB first under a
// start/busy/done handshake, with a golden predictor for overlapping PATTERN hits.
module seq_1101_frame_tx #(
  parameter int unsigned WIDTH   = 16,
  parameter logic [3:0]  PATTERN = 4'b1101,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             dout_o,
  output logic             dvalid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             exp_match_o,
  output logic [CNT_W-1:0] match_count_o
);

  localparam int unsigned BCNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   shreg_q;
  logic [BCNT_W-1:0]  bit_cnt_q;
  logic               dout_q;
  logic               dvalid_q;
  logic               busy_q;
  logic               done_q;
  logic [2:0]         hist_q;
  logic [CNT_W-1:0]   match_count_q;
  logic [CNT_W-1:0]   match_count_d;
  logic               exp_match;

  // The last three emitted bits plus the bit on dout complete the pattern.
  assign exp_match = (hist_q == PATTERN[3:1]) && dout_q && dvalid_q;

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    match_count_d = match_count_q;
    if (exp_match && (match_count_q != {CNT_W{1'b1}})) begin
      match_count_d = match_count_q + CNT_W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; a later assignment in the block overrides an earlier one.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      dout_q        <= 1'b0;
      dvalid_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hist_q        <= '0;
      match_count_q <= '0;
    end else begin
      hist_q        <= {hist_q[1:0], dout_q};
      match_count_q <= match_count_d;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q       <= S_SHIFT;
            // shreg holds only the bits still to be sent; the MSB goes straight to dout.
            shreg_q       <= {data_i[WIDTH-2:0], 1'b0};
            dout_q        <= data_i[WIDTH-1];
            dvalid_q      <= 1'b1;
            busy_q        <= 1'b1;
            bit_cnt_q     <= BCNT_W'(WIDTH - 1);
            match_count_q <= '0;
          end
        end
        S_SHIFT: begin
          if (bit_cnt_q == '0) begin
            state_q  <= S_DONE;
            dout_q   <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            dout_q    <= shreg_q[WIDTH-1];
            shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
            bit_cnt_q <= bit_cnt_q - BCNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dout_o        = dout_q;
  assign dvalid_o      = dvalid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign exp_match_o   = exp_match;
  assign match_count_o = match_count_q;

endmodule

// File: tb/tb_seq_1101_frame_tx.sv
// Bench for seq_1101_frame_tx: a frame-level model checked every cycle, plus
// directed frames with hand-computed match positions and counts.
module tb_seq_1101_frame_tx;

  localparam int W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data  = '0;

  logic       dout, dvalid, busy, done, exp_match;
  logic [7:0] match_count;
  logic       dout_s, dvalid_s, busy_s, done_s, exp_match_s;
  logic [1:0] match_count_s;

  int total = 0;
  int bad   = 0;

  seq_1101_frame_tx #(.WIDTH(W), .PATTERN(4'b1101), .CNT_W(8)) dut (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .data_i(data),
    .dout_o(dout), .dvalid_o(dvalid), .busy_o(busy), .done_o(done),
    .exp_match_o(exp_match), .match_count_o(match_count)
  );

  seq_1101_frame_tx #(.WIDTH(W), .PATTERN(4'b1101), .CNT_W(2)) dut_s (
    .clock_i(clk), .reset_i(rst_n), .start_i(start), .data_i(data),
    .dout_o(dout_s), .dvalid_o(dvalid_s), .busy_o(busy_s), .done_o(done_s),
    .exp_match_o(exp_match_s), .match_count_o(match_count_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: m_pos is -1 when no frame, 0..W-1 for the bit on the
  // line, W for the done cycle. m_hist holds the last three bits seen on the line.
  int           m_pos  = -1;
  logic [W-1:0] m_word = '0;
  logic [2:0]   m_hist = '0;
  int           m_cnt  = 0;

  logic e_valid, e_dout, e_done, e_match;
  int   e_idx, e_cnt8, e_cnt2;

  always_comb begin
    e_valid = (m_pos >= 0) && (m_pos < W);
    e_idx   = 0;
    if (e_valid) e_idx = W - 1 - m_pos;
    e_dout  = e_valid && m_word[e_idx[3:0]];
    e_done  = (m_pos == W);
    e_match = e_valid && ({m_hist, e_dout} == 4'b1101);
    e_cnt8  = (m_cnt > 255) ? 255 : m_cnt;
    e_cnt2  = (m_cnt > 3) ? 3 : m_cnt;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  <= -1;
      m_word <= '0;
      m_hist <= '0;
      m_cnt  <= 0;
    end else begin
      m_hist <= {m_hist[1:0], e_dout};
      if (m_pos == -1) begin
        if (start) begin
          m_pos  <= 0;
          m_word <= data;
          m_cnt  <= 0;
        end
      end else begin
        if (e_match) m_cnt <= m_cnt + 1;
        m_pos <= (m_pos == W) ? -1 : m_pos + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_dout",      {31'd0, dout},        {31'd0, e_dout});
      check("cyc_dvalid",    {31'd0, dvalid},      {31'd0, e_valid});
      check("cyc_busy",      {31'd0, busy},        {31'd0, e_valid});
      check("cyc_done",      {31'd0, done},        {31'd0, e_done});
      check("cyc_match",     {31'd0, exp_match},   {31'd0, e_match});
      check("cyc_count",     {24'd0, match_count}, e_cnt8);
      check("cyc_dout_s",    {31'd0, dout_s},      {31'd0, e_dout});
      check("cyc_match_s",   {31'd0, exp_match_s}, {31'd0, e_match});
      check("cyc_count_sat", {30'd0, match_count_s}, e_cnt2);
    end
  end

  task automatic check_all_zero(input string name);
    check(name, {dout, dvalid, busy, done, exp_match, match_count,
                 dout_s, dvalid_s, busy_s, done_s, exp_match_s, match_count_s}, 32'd0);
  endtask

  // Starts a frame at the next edge (called at a negedge), records in which
  // cycle after the accept edge exp_match and done appear, and returns at the
  // negedge of the idle cycle so a following call starts back-to-back.
  task automatic send_frame(input logic [W-1:0] d, input logic [31:0] exp_mask,
                            input int exp_cnt, input int exp_cnt_s,
                            input int pulse_at, input string name);
    logic [31:0] seen;
    int          done_at;
    seen    = '0;
    done_at = -1;
    start   = 1'b1;
    data    = d;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      start = (c == pulse_at);
      if (exp_match) seen[c] = 1'b1;
      if (done && done_at < 0) begin
        done_at = c;
        check({name, "_count"}, {24'd0, match_count}, exp_cnt);
        check({name, "_count_sat"}, {30'd0, match_count_s}, exp_cnt_s);
      end
    end
    start = 1'b0;
    check({name, "_match_cycles"}, seen, exp_mask);
    check({name, "_done_cycle"}, done_at, W + 1);
    check({name, "_idle_after"}, {29'd0, busy, dvalid, done}, 32'd0);
  endtask

  initial begin
    int done_cycles[3];
    int n_done;
    int idle_bad;

    #12;
    check_all_zero("reset_state");
    @(negedge clk) rst_n = 1'b1;

    // 1101101101101101: hits on cycles 4,7,10,13,16
    send_frame(16'hDB6D, 32'h0001_2490, 5, 3, 0, "overlap");
    send_frame(16'h0000, 32'h0, 0, 0, 0, "nomatch");
    send_frame(16'h0003, 32'h0, 0, 0, 0, "bound_a");
    send_frame(16'h8000, 32'h0, 0, 0, 0, "bound_b");
    // 1011011011011011: hits on cycles 6,9,12,15; stray start in cycle 5
    send_frame(16'hB6DB, 32'h0000_9240, 4, 3, 5, "busy_start");

    // Held start: a new frame every W+2 cycles.
    n_done = 0;
    data   = 16'hA5A5;
    start  = 1'b1;
    for (int c = 0; c < 80 && n_done < 3; c++) begin
      @(negedge clk);
      if (done) begin
        done_cycles[n_done] = c;
        n_done++;
      end
    end
    start = 1'b0;
    check("hold_pulses", n_done, 3);
    if (n_done == 3) begin
      check("hold_period_1", done_cycles[1] - done_cycles[0], W + 2);
      check("hold_period_2", done_cycles[2] - done_cycles[1], W + 2);
    end
    @(negedge clk);

    // Reset in cycle 5 of a frame: outputs clear at once, no done pulse follows.
    start = 1'b1;
    data  = 16'hDB6D;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_count", {24'd0, match_count}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_midframe");
    @(negedge clk) rst_n = 1'b1;
    idle_bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy || dvalid) idle_bad++;
    end
    check("reset_no_done", idle_bad, 0);
    send_frame(16'hDB6D, 32'h0001_2490, 5, 3, 0, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench did not terminate");
  end

endmodule
